// File: rtl/fwd_hazard_unit_if.sv
// Bundle of EX/ID-stage signals shared between the pipeline and fwd_hazard_unit.
// All inputs are level signals sampled every cycle; there is no valid/ready handshake.
interface fwd_hazard_unit_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSTG = 2
);
  logic [AW-1:0]      rs_addr_ex;
  logic [AW-1:0]      rt_addr_ex;
  logic [DW-1:0]      rs_data_ex;
  logic [DW-1:0]      rt_data_ex;
  logic [NSTG-1:0]    stg_wr_en;
  logic [NSTG*AW-1:0] stg_wr_addr;
  logic [NSTG*DW-1:0] stg_wr_data;
  logic               mem_read_ex;
  logic [AW-1:0]      wr_addr_ex;
  logic [AW-1:0]      rs_addr_id;
  logic [AW-1:0]      rt_addr_id;
  logic [DW-1:0]      opa;
  logic [DW-1:0]      opb;
  logic [NSTG:0]      fwd_sel_a;
  logic [NSTG:0]      fwd_sel_b;
  logic               stall;
  logic               flush_idex;
  logic               dbg_state;

  modport master (
    output rs_addr_ex, rt_addr_ex, rs_data_ex, rt_data_ex,
    output stg_wr_en, stg_wr_addr, stg_wr_data,
    output mem_read_ex, wr_addr_ex, rs_addr_id, rt_addr_id,
    input  opa, opb, fwd_sel_a, fwd_sel_b, stall, flush_idex, dbg_state
  );

  modport slave (
    input  rs_addr_ex, rt_addr_ex, rs_data_ex, rt_data_ex,
    input  stg_wr_en, stg_wr_addr, stg_wr_data,
    input  mem_read_ex, wr_addr_ex, rs_addr_id, rt_addr_id,
    output opa, opb, fwd_sel_a, fwd_sel_b, stall, flush_idex, dbg_state
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use stall FSM for the pipelined MIPS core.
// Optional FWD_STATS_EN adds saturating forward/stall event counters.
module fwd_hazard_unit #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NSTG     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  fwd_hazard_unit_if.slave bus
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]     fwd_cnt_a,
  output logic [31:0]     fwd_cnt_b,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int CW = $clog2(LOAD_LAT) + 1;
  localparam logic [CW-1:0] CNT_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          haz;
  logic          stall_c;
  logic [NSTG:0] sel_a, sel_b;
  logic [DW-1:0] opa_c, opb_c;

  // Scan oldest to nearest so the lowest matching stage overrides the rest.
  always_comb begin
    sel_a = (NSTG+1)'(1);
    sel_b = (NSTG+1)'(1);
    opa_c = bus.rs_data_ex;
    opb_c = bus.rt_data_ex;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (bus.stg_wr_en[i] && (bus.rs_addr_ex != '0) &&
          (bus.stg_wr_addr[i*AW +: AW] == bus.rs_addr_ex)) begin
        sel_a = (NSTG+1)'(1) << (i + 1);
        opa_c = bus.stg_wr_data[i*DW +: DW];
      end
      if (bus.stg_wr_en[i] && (bus.rt_addr_ex != '0) &&
          (bus.stg_wr_addr[i*AW +: AW] == bus.rt_addr_ex)) begin
        sel_b = (NSTG+1)'(1) << (i + 1);
        opb_c = bus.stg_wr_data[i*DW +: DW];
      end
    end
  end

  assign bus.opa       = opa_c;
  assign bus.opb       = opb_c;
  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;

  assign haz = bus.mem_read_ex && (bus.wr_addr_ex != '0) &&
               ((bus.wr_addr_ex == bus.rs_addr_id) || (bus.wr_addr_ex == bus.rt_addr_id));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The IDLE detection cycle is the first stall cycle; STALL supplies the remaining LOAD_LAT-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_c  = 1'b0;
    case (state)
      IDLE: begin
        if (haz) begin
          stall_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nx = STALL;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      STALL: begin
        stall_c = 1'b1;
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.stall      = stall_c && !rst;
  assign bus.flush_idex = stall_c && !rst;
  assign bus.dbg_state  = state;

`ifdef FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_cnt_a <= '0;
      fwd_cnt_b <= '0;
      stall_cnt <= '0;
    end else begin
      if (!sel_a[0] && (fwd_cnt_a != 32'hFFFF_FFFF)) fwd_cnt_a <= fwd_cnt_a + 32'd1;
      if (!sel_b[0] && (fwd_cnt_b != 32'hFFFF_FFFF)) fwd_cnt_b <= fwd_cnt_b + 32'd1;
      if (stall_c && (stall_cnt != 32'hFFFF_FFFF))   stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
